// File: rtl/dds_pkg.sv
// Shared constants, stage record and quarter-sine table generator for the DDS wave source.
// The table generator runs only at elaboration and so costs no logic.
package dds_pkg;

    localparam int PHASE_W   = 10;
    localparam int LUT_AW    = 8;
    localparam int MAG_W     = 7;
    localparam int WAVE_W    = 8;
    localparam int LUT_DEPTH = 1 << LUT_AW;

    localparam logic [WAVE_W-1:0] SIN_MID = 8'd128;
    localparam logic [WAVE_W-1:0] SQU_HI  = 8'hFF;
    localparam logic [WAVE_W-1:0] SQU_LO  = 8'h00;

    // Phase sample travelling down the pipeline with its overflow flag
    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic               ovf;
    } stage_t;

    localparam int     FX_FRAC    = 30;
    localparam longint HALF_PI_FX = 64'sd1686629713;

    // round(127 * sin(pi/2 * (idx + 0.5) / 256)) using a fixed-point Taylor series
    function automatic logic [MAG_W-1:0] quarter_sine(input int idx);
        longint x;
        longint term;
        longint sum;
        x    = (HALF_PI_FX * longint'(2 * idx + 1)) / longint'(2 * LUT_DEPTH);
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = (term * x) >>> FX_FRAC;
            term = -((term * x) >>> FX_FRAC) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        sum = (sum * 127 + (longint'(1) <<< (FX_FRAC - 1))) >>> FX_FRAC;
        return sum[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// 256 x 7 quarter-wave sine magnitude table with registered, enabled read.
// Entries are half-sample offset so mirrored quadrants match exactly.
module sine_quarter_rom
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr,
    output logic [MAG_W-1:0]  data
);

    logic [MAG_W-1:0] rom_table [LUT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
            localparam logic [MAG_W-1:0] ENTRY = quarter_sine(gi);
            assign rom_table[gi] = ENTRY;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (en) begin
            data <= rom_table[addr];
        end
    end

endmodule

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS producing time-aligned sine, square, triangle and sawtooth.
// Three-stage pipeline: phase register, quarter-sine ROM read, wave shaping.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int               ACC_W         = 32,
    parameter logic [ACC_W-1:0] DEFAULT_FWORD = 32'h0100_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               fword_load,
    input  logic [ACC_W-1:0]   fword,
    input  logic [PHASE_W-1:0] poff,
    output logic [WAVE_W-1:0]  wave_sin,
    output logic [WAVE_W-1:0]  wave_squ,
    output logic [WAVE_W-1:0]  wave_tri,
    output logic [WAVE_W-1:0]  wave_saw,
    output logic               wave_valid,
    output logic               wrap
);

    logic [ACC_W-1:0]   fword_reg;
    logic [PHASE_W-1:0] poff_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_next;
    logic [PHASE_W-1:0] phase_next;
    stage_t             s1_reg;
    stage_t             s2_reg;
    logic [LUT_AW-1:0]  rom_addr;
    logic [MAG_W-1:0]   rom_mag;
    logic [1:0]         fill_reg;
    logic [1:0]         fill_next;

    assign {ovf_next, acc_next} = {1'b0, acc_reg} + {1'b0, fword_reg};
    assign phase_next = acc_reg[ACC_W-1 -: PHASE_W] + poff_reg;
    assign fill_next  = (fill_reg == 2'd3) ? 2'd3 : fill_reg + 2'd1;

    // Odd quadrants walk the quarter table backwards
    assign rom_addr = s1_reg.phase[LUT_AW] ? ~s1_reg.phase[LUT_AW-1:0]
                                           : s1_reg.phase[LUT_AW-1:0];

    // The load uses the old word for this edge's add; the new word applies from the next edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fword_reg <= DEFAULT_FWORD;
            poff_reg  <= '0;
        end else if (fword_load) begin
            fword_reg <= fword;
            poff_reg  <= poff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            s1_reg   <= '0;
            s2_reg   <= '0;
            fill_reg <= '0;
        end else if (en) begin
            acc_reg      <= acc_next;
            s1_reg.phase <= phase_next;
            s1_reg.ovf   <= ovf_next;
            s2_reg       <= s1_reg;
            fill_reg     <= fill_next;
        end
    end

    sine_quarter_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (rom_addr),
        .data  (rom_mag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_sin   <= '0;
            wave_squ   <= '0;
            wave_tri   <= '0;
            wave_saw   <= '0;
            wave_valid <= 1'b0;
            wrap       <= 1'b0;
        end else if (en) begin
            wave_sin   <= s2_reg.phase[PHASE_W-1] ? (SIN_MID - 8'd1 - {1'b0, rom_mag})
                                                  : (SIN_MID + {1'b0, rom_mag});
            wave_squ   <= s2_reg.phase[PHASE_W-1] ? SQU_LO : SQU_HI;
            wave_tri   <= s2_reg.phase[PHASE_W-1] ? ~s2_reg.phase[PHASE_W-2:1]
                                                  : s2_reg.phase[PHASE_W-2:1];
            wave_saw   <= s2_reg.phase[PHASE_W-1:2];
            wave_valid <= (fill_next == 2'd3);
            wrap       <= s2_reg.ovf;
        end else begin
            wave_valid <= 1'b0;
            wrap       <= 1'b0;
        end
    end

endmodule
